// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers (one bit per cycle).
// Divide datapath is present only when MULDIV_DIV_EN is defined; otherwise a divide request ends in err.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             div,
    input  logic             unsig,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state | meaning
    // IDLE  | waiting for start, HI/LO direct writes accepted
    // CALC  | one shift-add / shift-subtract step per cycle, WIDTH cycles
    // FIX   | sign correction, HI/LO written
    // DONE  | one-cycle done (and err) pulse
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] acc_neg;
    logic [WIDTH-1:0]   op_m;
    logic               neg_res;
    logic               err_r;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               div_sel;
    logic               start_err;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign a_neg = ~unsig & a[WIDTH-1];
    assign b_neg = ~unsig & b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, op_m};
    assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    assign acc_neg  = -acc;

`ifdef MULDIV_DIV_EN
    logic               op_div;
    logic               neg_rem;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;

    assign div_sel   = div;
    assign start_err = div & (b == '0);
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, op_m};
    assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`else
    assign div_sel   = 1'b0;
    assign start_err = div;
`endif

    always_comb begin
        acc_step = mul_next;
        fix_hi   = neg_res ? acc_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_lo   = neg_res ? acc_neg[WIDTH-1:0] : acc[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (op_div) begin
            acc_step = div_next;
            fix_lo   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_hi   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            op_m    <= '0;
            neg_res <= 1'b0;
            err_r   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef MULDIV_DIV_EN
            op_div  <= 1'b0;
            neg_rem <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt     <= CNT_LOAD;
                        err_r   <= start_err;
                        neg_res <= a_neg ^ b_neg;
                        op_m    <= div_sel ? mag_b : mag_a;
                        acc     <= {{WIDTH{1'b0}}, (div_sel ? mag_a : mag_b)};
`ifdef MULDIV_DIV_EN
                        op_div  <= div;
                        neg_rem <= a_neg;
`endif
                        state   <= start_err ? S_DONE : S_CALC;
                    end else begin
                        err_r <= 1'b0;
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                S_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_CALC) || (state == S_FIX);
    assign done = (state == S_DONE);
    assign err  = done & err_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): vector table plus hand-written overlap/reset sequences.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start, div, unsig, hi_we, lo_we;
    logic [31:0] a, b, wdata;
    logic        busy, done, err;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi, m_lo;

    typedef struct {
        logic        div;
        logic        unsig;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .div(div), .unsig(unsig),
        .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic d, input logic u, input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] eh, input logic [31:0] el, input logic ee);
        vec_t v;
        v.div = d; v.unsig = u; v.a = av; v.b = bv; v.hi = eh; v.lo = el; v.err = ee;
        if (d && !DIV_EN) v.err = 1'b1;
        vecs.push_back(v);
    endfunction

    task automatic run_op(input logic d, input logic u, input logic [31:0] av, input logic [31:0] bv,
                          input int inj, input logic wr_start,
                          output int edge_n, output logic err_o, output logic [31:0] hi_o,
                          output logic [31:0] lo_o, output logic busy_o);
        @(negedge clock);
        start = 1'b1; div = d; unsig = u; a = av; b = bv;
        if (wr_start) begin
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
        end
        edge_n = 0; err_o = 1'b0; hi_o = '0; lo_o = '0; busy_o = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; a = '0; b = '0;
            if (i == 5) busy_o = busy;
            if (done && edge_n == 0) begin
                edge_n = i; err_o = err; hi_o = hi; lo_o = lo;
            end
            if (i == inj) begin
                start = 1'b1; div = 1'b0; unsig = 1'b1; a = '1; b = '1;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
            end
            if (edge_n != 0) break;
        end
    endtask

    initial begin
        int          edge_n, done_cnt;
        logic        err_o, busy_o;
        logic [31:0] hi_o, lo_o, exp_hi, exp_lo;
        vec_t        v;

        reset = 1'b0; start = 1'b0; div = 1'b0; unsig = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clock);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b1;

        // direct HI/LO writes
        @(negedge clock);
        hi_we = 1'b1; wdata = 32'h11112222;
        @(negedge clock);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h33334444;
        chk("mthi", hi, 32'h11112222);
        @(negedge clock);
        lo_we = 1'b0;
        chk("mtlo", lo, 32'h33334444);
        m_hi = 32'h11112222; m_lo = 32'h33334444;

        // divide by zero with a simultaneous write: write dropped, err on edge 1
        run_op(1'b1, 1'b1, 32'd7, 32'd0, 0, 1'b1, edge_n, err_o, hi_o, lo_o, busy_o);
        chk("dz_edge", edge_n, 32'd1);
        chk("dz_err", {31'd0, err_o}, 32'd1);
        chk("dz_hi", hi_o, m_hi);
        chk("dz_lo", lo_o, m_lo);

        add(1'b0, 1'b0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        add(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        add(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
        add(1'b0, 1'b1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0);
        add(1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        add(1'b0, 1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        add(1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        add(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        add(1'b1, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        add(1'b1, 1'b1, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999, 1'b0);
        add(1'b1, 1'b0, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
        add(1'b0, 1'b1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        add(1'b1, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1);

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            run_op(v.div, v.unsig, v.a, v.b, 0, 1'b0, edge_n, err_o, hi_o, lo_o, busy_o);
            exp_hi = v.err ? m_hi : v.hi;
            exp_lo = v.err ? m_lo : v.lo;
            chk($sformatf("v%0d_edge", k), edge_n, v.err ? 32'd1 : 32'd34);
            chk($sformatf("v%0d_err", k), {31'd0, err_o}, {31'd0, v.err});
            chk($sformatf("v%0d_hi", k), hi_o, exp_hi);
            chk($sformatf("v%0d_lo", k), lo_o, exp_lo);
            if (!v.err) chk($sformatf("v%0d_busy", k), {31'd0, busy_o}, 32'd1);
            m_hi = exp_hi; m_lo = exp_lo;
        end

        // start and HI/LO writes during CALC are ignored
        run_op(1'b0, 1'b1, 32'd3, 32'd5, 10, 1'b0, edge_n, err_o, hi_o, lo_o, busy_o);
        chk("ovl_edge", edge_n, 32'd34);
        chk("ovl_err", {31'd0, err_o}, 32'd0);
        chk("ovl_hi", hi_o, 32'd0);
        chk("ovl_lo", lo_o, 32'd15);
        @(negedge clock);
        @(negedge clock);
        chk("ovl_idle_busy", {31'd0, busy}, 32'd0);
        chk("ovl_lo_after", lo, 32'd15);

        // reset in the middle of an operation
        @(negedge clock);
        start = 1'b1; div = 1'b0; unsig = 1'b1; a = 32'd3; b = 32'd5;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        chk("mid_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_hi", hi, 32'd0);
        chk("mid_lo", lo, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || busy) done_cnt++;
        end
        chk("mid_no_resume", done_cnt, 32'd0);
        lo_we = 1'b1; wdata = 32'h12345678;
        @(negedge clock);
        lo_we = 1'b0;
        chk("post_mtlo", lo, 32'h12345678);
        chk("post_hi", hi, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width (legal values are even numbers of 8 or more).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to begin an operation.
REQ-005 SHALL have port div, input, 1 bit: 0 selects multiply, 1 selects divide; sampled with start.
REQ-006 SHALL have port unsig, input, 1 bit: 1 selects unsigned, 0 selects two's-complement; sampled with start.
REQ-007 SHALL have ports a and b, inputs, WIDTH bits each: multiplicand/dividend and multiplier/divisor; sampled with start.
REQ-008 SHALL have ports hi_we and lo_we, inputs, 1 bit each, and wdata, input, WIDTH bits: direct HI/LO writes (MTHI/MTLO).
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when hi/lo hold the new result.
REQ-011 SHALL have port err, output, 1 bit: pulses together with done on divide-by-zero or an unsupported operation.
REQ-012 SHALL have ports hi and lo, outputs, WIDTH bits each: registered HI/LO contents.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX and DONE; busy SHALL be 1 in CALC and FIX.
REQ-014 In IDLE, start=1 SHALL latch the inputs, load the operand magnitudes (absolute values when unsig=0) and move to CALC.
REQ-015 CALC SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly WIDTH cycles, using an internal iteration counter.
REQ-016 FIX SHALL, when unsig=0, negate the product if the operand signs differ, negate the quotient if the signs differ, and give the remainder the sign of the dividend; it SHALL then write hi/lo.
REQ-017 Multiply SHALL produce the full 2*WIDTH-bit product, with hi holding the upper half and lo the lower half.
REQ-018 Divide SHALL give lo=quotient and hi=remainder; signed minimum divided by -1 SHALL give lo=minimum value and hi=0 (wrap, no err).
REQ-019 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-020 Latency: done SHALL be high on the (WIDTH+2)th rising edge after the start edge.
REQ-021 Divide with b=0 SHALL skip CALC and FIX, go directly to DONE (done on the 1st edge after start), assert err, and leave hi/lo unchanged.
REQ-022 start while busy SHALL be ignored, and hi_we/lo_we while busy SHALL be ignored.
REQ-023 In IDLE, hi_we/lo_we SHALL load wdata into hi/lo at the next edge; if start is also high, start SHALL win and the write SHALL be dropped.
REQ-024 hi/lo SHALL change only in FIX or through REQ-023.

Reset
REQ-025 reset=0 SHALL, at any time including mid-operation, force IDLE with busy=0, done=0, err=0, hi=0, lo=0, and clear the iteration counter and working registers.
REQ-026 No operation SHALL resume after reset is released.

Configuration
REQ-027 With macro MULDIV_DIV_EN defined, divide SHALL be built as specified above.
REQ-028 Without MULDIV_DIV_EN, there SHALL be no divide datapath; start with div=1 SHALL go directly to DONE with err=1 and hi/lo unchanged, and multiply SHALL be unaffected.

Verification (WIDTH=32)
REQ-029 Signed multiply a=FFFFFFFD, b=00000005 -> on edge 34, done=1, hi=FFFFFFFF, lo=FFFFFFF1, err=0.
REQ-030 Unsigned multiply a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; signed multiply with the same operands -> hi=00000000, lo=00000001.
REQ-031 Signed divide a=FFFFFFF9, b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; signed divide a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-032 Unsigned divide a=7, b=0 -> done and err on edge 1, hi/lo keep prior values; without MULDIV_DIV_EN, any divide -> the same response.
REQ-033 Second start and hi_we pulse during CALC -> both ignored, and the first result is delivered on edge 34 intact.
REQ-034 reset pulsed low at cycle 10 of an operation -> immediately busy=0 and hi=lo=0, with no done afterwards; a subsequent MTLO with wdata=12345678 -> lo=12345678 on the next edge.
